// File: rtl/i2s_rate_ctrl_pkg.sv
// Shared definitions for the I2S rate-change controller: sequencer states and
// the codec sample-rate control word layout.
package i2s_rate_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DISABLE,
    ST_SHIFT,
    ST_SETTLE,
    ST_WAITV
  } state_t;

  localparam int         WORD_W      = 16;
  localparam logic [6:0] CODEC_ADDR  = 7'h08;
  localparam logic [2:0] WORD_PAD    = 3'b000;
  localparam logic       WORD_ACTIVE = 1'b1;

  // Sampling-control register word: address, padding, SR code, BOSR, active bit.
  function automatic logic [WORD_W-1:0] codec_word(input logic [3:0] sr, input logic bosr);
    return {CODEC_ADDR, WORD_PAD, sr, bosr, WORD_ACTIVE};
  endfunction

endpackage

// File: rtl/i2s_rate_ctrl_spi.sv
// 3-wire codec control-port transmitter: one 16-bit word, MSB first, data
// launched with the falling clock, followed by a chip-select-high hold.
module codec_spi_tx
  import i2s_rate_ctrl_pkg::*;
#(
  parameter int SPI_DIV = 25
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [WORD_W-1:0] data,
  output logic              busy,
  output logic              finish,
  output logic              cs_n,
  output logic              csclk,
  output logic              csdat
);

  typedef enum logic [1:0] {TX_IDLE, TX_LOW, TX_HIGH, TX_TAIL} tx_t;

  localparam int DIV_W = (SPI_DIV > 1) ? $clog2(SPI_DIV) : 1;
  localparam int IDX_W = $clog2(WORD_W);
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(SPI_DIV - 1);
  localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(WORD_W - 1);

  tx_t               phase, phase_nxt;
  logic [DIV_W-1:0]  div_cnt, div_cnt_nxt;
  logic [IDX_W-1:0]  bit_idx, bit_idx_nxt;
  logic [WORD_W-1:0] shreg, shreg_nxt;
  logic              cs_n_nxt, csclk_nxt, csdat_nxt;
  logic              div_end;

  assign div_end = (div_cnt == '0);
  assign busy    = (phase != TX_IDLE);

  always_comb begin
    phase_nxt   = phase;
    div_cnt_nxt = div_cnt;
    bit_idx_nxt = bit_idx;
    shreg_nxt   = shreg;
    cs_n_nxt    = cs_n;
    csclk_nxt   = csclk;
    csdat_nxt   = csdat;
    finish      = 1'b0;
    unique case (phase)
      TX_IDLE: begin
        if (start) begin
          phase_nxt   = TX_LOW;
          div_cnt_nxt = DIV_LOAD;
          bit_idx_nxt = '0;
          shreg_nxt   = {data[WORD_W-2:0], 1'b0};
          cs_n_nxt    = 1'b0;
          csdat_nxt   = data[WORD_W-1];
        end
      end
      TX_LOW: begin
        if (div_end) begin
          phase_nxt   = TX_HIGH;
          div_cnt_nxt = DIV_LOAD;
          csclk_nxt   = 1'b1;
        end else begin
          div_cnt_nxt = div_cnt - DIV_W'(1);
        end
      end
      TX_HIGH: begin
        if (div_end) begin
          div_cnt_nxt = DIV_LOAD;
          csclk_nxt   = 1'b0;
          if (bit_idx == LAST_BIT) begin
            phase_nxt = TX_TAIL;
            cs_n_nxt  = 1'b1;
            csdat_nxt = 1'b0;
          end else begin
            // Next bit is launched together with the falling clock edge.
            phase_nxt   = TX_LOW;
            bit_idx_nxt = bit_idx + IDX_W'(1);
            csdat_nxt   = shreg[WORD_W-1];
            shreg_nxt   = {shreg[WORD_W-2:0], 1'b0};
          end
        end else begin
          div_cnt_nxt = div_cnt - DIV_W'(1);
        end
      end
      TX_TAIL: begin
        if (div_end) begin
          phase_nxt = TX_IDLE;
          finish    = 1'b1;
        end else begin
          div_cnt_nxt = div_cnt - DIV_W'(1);
        end
      end
      default: phase_nxt = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase   <= TX_IDLE;
      div_cnt <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      cs_n    <= 1'b1;
      csclk   <= 1'b0;
      csdat   <= 1'b0;
    end else begin
      phase   <= phase_nxt;
      div_cnt <= div_cnt_nxt;
      bit_idx <= bit_idx_nxt;
      shreg   <= shreg_nxt;
      cs_n    <= cs_n_nxt;
      csclk   <= csclk_nxt;
      csdat   <= csdat_nxt;
    end
  end

endmodule

// File: rtl/i2s_rate_ctrl.sv
// I2S sample-rate change sequencer: quiesce the port, program the codec over
// its control port, let it settle, then re-enable and wait for the first sample.
module i2s_rate_ctrl
  import i2s_rate_ctrl_pkg::*;
#(
  parameter int SPI_DIV = 25,
  parameter int QUIESCE = 64,
  parameter int SETTLE  = 50000,
  parameter int TIMEOUT = 4096
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req,
  input  logic       req_bosr,
  input  logic [3:0] req_sr,
  input  logic       valid,
  output logic       outena,
  output logic       bosr,
  output logic [3:0] sr,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       cs_n,
  output logic       csclk,
  output logic       csdat
);

  localparam int MAX_QS  = (QUIESCE > SETTLE) ? QUIESCE : SETTLE;
  localparam int CNT_MAX = (MAX_QS > TIMEOUT) ? MAX_QS : TIMEOUT;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             outena_nxt, bosr_nxt, busy_nxt, done_nxt, err_nxt;
  logic [3:0]       sr_nxt;
  logic             tx_start, tx_busy, tx_finish;
  logic             cnt_zero;

  assign cnt_zero = (cnt == '0);

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    outena_nxt = outena;
    bosr_nxt   = bosr;
    sr_nxt     = sr;
    busy_nxt   = busy;
    done_nxt   = 1'b0;
    err_nxt    = err;
    tx_start   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (req) begin
          state_nxt  = ST_DISABLE;
          cnt_nxt    = CNT_W'(QUIESCE - 1);
          bosr_nxt   = req_bosr;
          sr_nxt     = req_sr;
          err_nxt    = 1'b0;
          busy_nxt   = 1'b1;
          outena_nxt = 1'b0;
        end
      end
      ST_DISABLE: begin
        if (!cnt_zero) begin
          cnt_nxt = cnt - CNT_W'(1);
        end else if (!tx_busy) begin
          tx_start  = 1'b1;
          state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (tx_finish) begin
          state_nxt = ST_SETTLE;
          cnt_nxt   = CNT_W'(SETTLE - 1);
        end
      end
      ST_SETTLE: begin
        if (!cnt_zero) begin
          cnt_nxt = cnt - CNT_W'(1);
        end else begin
          state_nxt  = ST_WAITV;
          cnt_nxt    = CNT_W'(TIMEOUT - 1);
          outena_nxt = 1'b1;
        end
      end
      ST_WAITV: begin
        // A sample arriving on the last allowed cycle still counts as success.
        if (valid) begin
          state_nxt = ST_IDLE;
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
        end else if (cnt_zero) begin
          state_nxt  = ST_IDLE;
          done_nxt   = 1'b1;
          busy_nxt   = 1'b0;
          err_nxt    = 1'b1;
          outena_nxt = 1'b0;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      outena <= 1'b0;
      bosr   <= 1'b0;
      sr     <= 4'd0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      outena <= outena_nxt;
      bosr   <= bosr_nxt;
      sr     <= sr_nxt;
      busy   <= busy_nxt;
      done   <= done_nxt;
      err    <= err_nxt;
    end
  end

  codec_spi_tx #(
    .SPI_DIV(SPI_DIV)
  ) u_spi (
    .clk    (clk),
    .reset_n(reset_n),
    .start  (tx_start),
    .data   (codec_word(sr, bosr)),
    .busy   (tx_busy),
    .finish (tx_finish),
    .cs_n   (cs_n),
    .csclk  (csclk),
    .csdat  (csdat)
  );

endmodule
